// File: rtl/fizzbuzz_tx_sequencer_if.sv
// Byte handshake between the fizzbuzz sequencer and the serial transmitter.
interface fizzbuzz_tx_sequencer_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/fizzbuzz_tx_sequencer.sv
// Drives the fizzbuzz counter and streams each line as ASCII followed by CR LF.
// state    | meaning
// IDLE     | waiting for start
// RESTART  | fb_rst pulse, counter back to 1
// SETTLE   | wait for fizzbuzz line to settle
// LOAD     | capture line code and isnum
// CHAR     | send characters until terminator or 8 chars
// CR / LF  | send line ending
// ADVANCE  | fb_next pulse, next line
// FINISH   | done pulse
module fizzbuzz_tx_sequencer #(
    parameter int COUNT_MAX     = 100,
    parameter int COUNT_W       = 7,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic [31:0]        i_fb_line,
    input  logic               i_fb_isnum,
    output logic               o_fb_rst,
    output logic               o_fb_next,
    output logic               o_busy,
    output logic               o_done,
    output logic [COUNT_W-1:0] o_line_count,
    output logic               o_cur_isnum,
    fizzbuzz_tx_sequencer_if.master tx
);
    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_RESTART, S_SETTLE, S_LOAD, S_CHAR, S_CR, S_LF, S_ADVANCE, S_FINISH
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [31:0]        r_shreg;
    logic [3:0]         r_idx;
    logic [SET_W-1:0]   r_settle;
    logic [COUNT_W-1:0] r_line_count;
    logic               r_cur_isnum;

    logic [3:0] w_nib;
    logic [7:0] w_ascii;
    logic       w_char_end;
    logic       w_tx_valid;
    logic [7:0] w_tx_data;
    logic       w_accept;
    logic       w_fb_rst;
    logic       w_fb_next;
    logic       w_done;

    assign w_nib      = r_shreg[{r_idx[2:0], 2'b00} +: 4];
    assign w_char_end = r_idx[3] || (w_nib == 4'hF);
    assign w_accept   = w_tx_valid & tx.tx_ready;

    always_comb begin
        w_ascii = 8'h30 + {4'h0, w_nib};
        case (w_nib)
            4'd10:   w_ascii = 8'h42;
            4'd11:   w_ascii = 8'h46;
            4'd12:   w_ascii = 8'h69;
            4'd13:   w_ascii = 8'h75;
            4'd14:   w_ascii = 8'h7A;
            default: w_ascii = 8'h30 + {4'h0, w_nib};
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Handshake outputs decode registered state only, so tx_valid has no path from tx_ready.
    always_comb begin
        w_state_nxt = r_state;
        w_tx_valid  = 1'b0;
        w_tx_data   = 8'h00;
        w_fb_rst    = 1'b0;
        w_fb_next   = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE:    if (i_start) w_state_nxt = S_RESTART;
            S_RESTART: begin
                w_fb_rst    = 1'b1;
                w_state_nxt = S_SETTLE;
            end
            S_SETTLE:  if (r_settle == SET_W'(1)) w_state_nxt = S_LOAD;
            S_LOAD:    w_state_nxt = S_CHAR;
            S_CHAR: begin
                if (w_char_end) begin
                    w_state_nxt = S_CR;
                end else begin
                    w_tx_valid = 1'b1;
                    w_tx_data  = w_ascii;
                end
            end
            S_CR: begin
                w_tx_valid = 1'b1;
                w_tx_data  = 8'h0D;
                if (tx.tx_ready) w_state_nxt = S_LF;
            end
            S_LF: begin
                w_tx_valid = 1'b1;
                w_tx_data  = 8'h0A;
                if (tx.tx_ready)
                    w_state_nxt = (r_line_count == COUNT_W'(COUNT_MAX)) ? S_FINISH : S_ADVANCE;
            end
            S_ADVANCE: begin
                w_fb_next   = 1'b1;
                w_state_nxt = S_SETTLE;
            end
            S_FINISH: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shreg      <= '1;
            r_idx        <= '0;
            r_settle     <= '0;
            r_line_count <= '0;
            r_cur_isnum  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE:    if (i_start) r_line_count <= COUNT_W'(1);
                S_RESTART: r_settle <= SET_W'(SETTLE_CYCLES);
                S_SETTLE:  r_settle <= r_settle - SET_W'(1);
                S_LOAD: begin
                    r_shreg     <= i_fb_line;
                    r_cur_isnum <= i_fb_isnum;
                    r_idx       <= '0;
                end
                S_CHAR:    if (w_accept) r_idx <= r_idx + 4'd1;
                S_ADVANCE: begin
                    r_line_count <= r_line_count + COUNT_W'(1);
                    r_settle     <= SET_W'(SETTLE_CYCLES);
                end
                default: ;
            endcase
        end
    end

    assign tx.tx_valid    = w_tx_valid;
    assign tx.tx_data     = w_tx_data;
    assign o_fb_rst       = w_fb_rst;
    assign o_fb_next      = w_fb_next;
    assign o_done         = w_done;
    assign o_busy         = (r_state != S_IDLE);
    assign o_line_count   = r_line_count;
    assign o_cur_isnum    = r_cur_isnum;
endmodule

// File: tb/tb_fizzbuzz_tx_sequencer.sv
// Directed bench: models the fizzbuzz counter and checks the byte stream line by line.
module tb_fizzbuzz_tx_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] fb_line;
    logic        fb_isnum;
    logic        fb_rst, fb_next, busy, done, cur_isnum;
    logic [6:0]  line_count;

    fizzbuzz_tx_sequencer_if u_if();

    fizzbuzz_tx_sequencer #(.COUNT_MAX(100), .COUNT_W(7), .SETTLE_CYCLES(2)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
        .i_fb_line(fb_line), .i_fb_isnum(fb_isnum),
        .o_fb_rst(fb_rst), .o_fb_next(fb_next), .o_busy(busy), .o_done(done),
        .o_line_count(line_count), .o_cur_isnum(cur_isnum),
        .tx(u_if)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int fb_cnt = 1;
    int lf_cnt = 0, rst_cnt = 0, next_cnt = 0, done_cnt = 0, viol_cnt = 0;
    logic [7:0] rx_q[$];
    logic [7:0] run1_q[$];

    function automatic string line_text(int n);
        if (n % 15 == 0) return "FizzBuzz";
        if (n % 3 == 0)  return "Fizz";
        if (n % 5 == 0)  return "Buzz";
        return $sformatf("%0d", n);
    endfunction

    function automatic logic [3:0] char_code(byte c);
        case (c)
            "B": return 4'd10;
            "F": return 4'd11;
            "i": return 4'd12;
            "u": return 4'd13;
            "z": return 4'd14;
            default: return 4'(c - 8'h30);
        endcase
    endfunction

    function automatic logic [31:0] encode(int n);
        string s = line_text(n);
        logic [31:0] v = '1;
        for (int i = 0; i < s.len(); i++) v[4*i +: 4] = char_code(s[i]);
        return v;
    endfunction

    // fizzbuzz counter environment model
    always @(posedge clk) begin
        if (fb_rst)       fb_cnt <= 1;
        else if (fb_next) fb_cnt <= fb_cnt + 1;
    end
    assign fb_line  = encode(fb_cnt);
    assign fb_isnum = (fb_cnt % 3 != 0) && (fb_cnt % 5 != 0);

    always @(posedge clk) begin
        if (rst_n) begin
            if (u_if.tx_valid && u_if.tx_ready) begin
                rx_q.push_back(u_if.tx_data);
                if (u_if.tx_data == 8'h0A) lf_cnt++;
            end
            if (fb_rst)  rst_cnt++;
            if (fb_next) next_cnt++;
            if (done)    done_cnt++;
            if ((fb_rst && fb_next) || ((fb_rst || fb_next) && u_if.tx_valid)) viol_cnt++;
        end
    end

    task automatic clear_mon();
        rx_q.delete();
        lf_cnt = 0; rst_cnt = 0; next_cnt = 0; done_cnt = 0; viol_cnt = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_lf(int n, string name);
        int cyc = 0;
        while (lf_cnt < n && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        if (lf_cnt < n) begin
            total++; bad++;
            $display("FAIL %s timeout: lf=%0d wanted %0d", name, lf_cnt, n);
        end
    endtask

    task automatic check_tail(logic [7:0] exp[], string name);
        int off = rx_q.size() - exp.size();
        total++;
        if (off < 0) begin
            bad++;
            $display("FAIL %s: got %0d bytes, needed %0d", name, rx_q.size(), exp.size());
        end else begin
            for (int i = 0; i < exp.size(); i++) begin
                if (rx_q[off+i] !== exp[i]) begin
                    bad++;
                    $display("FAIL %s byte %0d: got %h expected %h", name, i, rx_q[off+i], exp[i]);
                    break;
                end
            end
        end
    endtask

    task automatic check_stream(string name);
        logic [7:0] exp_q[$];
        string s;
        for (int n = 1; n <= 100; n++) begin
            s = line_text(n);
            for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end
        total++;
        if (rx_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL %s length: got %0d expected %0d", name, rx_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                if (rx_q[i] !== exp_q[i]) begin
                    bad++;
                    $display("FAIL %s byte %0d: got %h expected %h", name, i, rx_q[i], exp_q[i]);
                    break;
                end
            end
        end
    endtask

    task automatic wait_done(string name);
        int cyc = 0;
        while (done !== 1'b1 && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL %s: done never pulsed", name);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        u_if.tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (fb_rst !== 1'b0)        begin bad++; $display("FAIL reset fb_rst: got %b expected 0", fb_rst); end
        total++; if (fb_next !== 1'b0)       begin bad++; $display("FAIL reset fb_next: got %b expected 0", fb_next); end
        total++; if (u_if.tx_valid !== 1'b0) begin bad++; $display("FAIL reset tx_valid: got %b expected 0", u_if.tx_valid); end
        total++; if (u_if.tx_data !== 8'h00) begin bad++; $display("FAIL reset tx_data: got %h expected 00", u_if.tx_data); end
        total++; if (busy !== 1'b0)          begin bad++; $display("FAIL reset busy: got %b expected 0", busy); end
        total++; if (done !== 1'b0)          begin bad++; $display("FAIL reset done: got %b expected 0", done); end
        total++; if (line_count !== 7'd0)    begin bad++; $display("FAIL reset line_count: got %0d expected 0", line_count); end
        total++; if (cur_isnum !== 1'b0)     begin bad++; $display("FAIL reset cur_isnum: got %b expected 0", cur_isnum); end
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_first_line();
        clear_mon();
        pulse_start();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL busy after start: got %b expected 1", busy); end
        wait_lf(1, "first_line");
        check_tail('{8'h31, 8'h0D, 8'h0A}, "line1");
        total++; if (line_count !== 7'd1) begin bad++; $display("FAIL line1 line_count: got %0d expected 1", line_count); end
        total++; if (rst_cnt !== 1)       begin bad++; $display("FAIL line1 fb_rst count: got %0d expected 1", rst_cnt); end
        total++; if (cur_isnum !== 1'b1)  begin bad++; $display("FAIL line1 cur_isnum: got %b expected 1", cur_isnum); end
    endtask

    task automatic test_stall();
        int cyc = 0;
        while (!(u_if.tx_valid === 1'b1 && u_if.tx_data === 8'h69) && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        u_if.tx_ready = 1'b0;
        total++;
        if (u_if.tx_data !== 8'h69) begin
            bad++;
            $display("FAIL stall: never saw 'i' offered, tx_data=%h", u_if.tx_data);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (u_if.tx_valid !== 1'b1 || u_if.tx_data !== 8'h69) begin
                bad++;
                $display("FAIL stall hold %0d: valid=%b data=%h expected 1/69", i, u_if.tx_valid, u_if.tx_data);
            end
        end
        u_if.tx_ready = 1'b1;
        wait_lf(3, "line3");
        check_tail('{8'h46, 8'h69, 8'h7A, 8'h7A, 8'h0D, 8'h0A}, "line3");
        total++; if (cur_isnum !== 1'b0) begin bad++; $display("FAIL line3 cur_isnum: got %b expected 0", cur_isnum); end
    endtask

    task automatic test_line15();
        wait_lf(15, "line15");
        check_tail('{8'h46, 8'h69, 8'h7A, 8'h7A, 8'h42, 8'h75, 8'h7A, 8'h7A, 8'h0D, 8'h0A}, "line15");
        total++; if (line_count !== 7'd15) begin bad++; $display("FAIL line15 line_count: got %0d expected 15", line_count); end
    endtask

    task automatic test_full_run();
        wait_done("full_run");
        total++; if (lf_cnt !== 100)  begin bad++; $display("FAIL full LF count: got %0d expected 100", lf_cnt); end
        total++; if (next_cnt !== 99) begin bad++; $display("FAIL full fb_next count: got %0d expected 99", next_cnt); end
        check_tail('{8'h42, 8'h75, 8'h7A, 8'h7A, 8'h0D, 8'h0A}, "line100");
        @(negedge clk);
        total++; if (busy !== 1'b0)     begin bad++; $display("FAIL busy after done: got %b expected 0", busy); end
        total++; if (done_cnt !== 1)    begin bad++; $display("FAIL done count: got %0d expected 1", done_cnt); end
        total++; if (viol_cnt !== 0)    begin bad++; $display("FAIL strobe overlap: got %0d cycles expected 0", viol_cnt); end
        check_stream("full_stream");
        run1_q = rx_q;
    endtask

    task automatic test_start_spam();
        int cyc = 0;
        clear_mon();
        pulse_start();
        while (done !== 1'b1 && cyc < 5000) begin
            @(negedge clk);
            start = (cyc % 7 == 0);
            cyc++;
        end
        start = 1'b0;
        total++;
        if (done !== 1'b1) begin bad++; $display("FAIL spam: done never pulsed"); end
        repeat (4) @(negedge clk);
        total++; if (rst_cnt !== 1)      begin bad++; $display("FAIL spam fb_rst count: got %0d expected 1", rst_cnt); end
        total++; if (next_cnt !== 99)    begin bad++; $display("FAIL spam fb_next count: got %0d expected 99", next_cnt); end
        total++; if (rx_q != run1_q)     begin bad++; $display("FAIL spam stream differs from first run: %0d vs %0d bytes", rx_q.size(), run1_q.size()); end
        check_stream("spam_stream");
    endtask

    task automatic test_mid_reset();
        int cyc = 0;
        clear_mon();
        pulse_start();
        wait_lf(6, "mid_reset");
        while (u_if.tx_valid !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({fb_rst, fb_next, u_if.tx_valid, u_if.tx_data, busy, done, line_count, cur_isnum} !== 21'd0) begin
            bad++;
            $display("FAIL mid reset outputs: valid=%b data=%h busy=%b lc=%0d isnum=%b expected all 0",
                     u_if.tx_valid, u_if.tx_data, busy, line_count, cur_isnum);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_mon();
        pulse_start();
        wait_lf(1, "restart_line1");
        check_tail('{8'h31, 8'h0D, 8'h0A}, "restart_line1");
        total++; if (rx_q.size() !== 3) begin bad++; $display("FAIL restart byte count: got %0d expected 3", rx_q.size()); end
        total++; if (rst_cnt !== 1)     begin bad++; $display("FAIL restart fb_rst count: got %0d expected 1", rst_cnt); end
        total++; if (line_count !== 7'd1) begin bad++; $display("FAIL restart line_count: got %0d expected 1", line_count); end
    endtask

    initial begin
        u_if.tx_ready = 1'b1;
        test_reset();
        test_first_line();
        test_stall();
        test_line15();
        test_full_run();
        test_start_spam();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
